// File: rtl/quad_cmd_pkg.sv
// Shared types and constants for the quadcopter command path.
package quad_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } rx_state_e;

  localparam logic [7:0] SET_PITCH    = 8'h02;
  localparam logic [7:0] SET_ROLL     = 8'h03;
  localparam logic [7:0] SET_YAW      = 8'h04;
  localparam logic [7:0] SET_THRST    = 8'h05;
  localparam logic [7:0] CALIBRATE    = 8'h06;
  localparam logic [7:0] EMER_LAND    = 8'h07;
  localparam logic [7:0] MOTORS_OFF   = 8'h08;
  localparam logic [7:0] RESP_POS_ACK = 8'hA5;

endpackage

// File: rtl/cmd_frame_assembler_if.sv
// UART-side and consumer-side signals of the command frame assembler.
// master = environment (UART + command consumer), slave = assembler.
interface cmd_frame_assembler_if;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_sent;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        frm_err;

  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    input  clr_rx_rdy, cmd_rdy, cmd, data, resp_sent, trmt, tx_data, frm_err
  );

  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, send_resp, resp, tx_done,
    output clr_rx_rdy, cmd_rdy, cmd, data, resp_sent, trmt, tx_data, frm_err
  );
endinterface

// File: rtl/resp_tx_buffer.sv
// Response transmit path: launches bytes to the UART with a 1-deep holding buffer.
module resp_tx_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_send_resp,
  input  logic [7:0] i_resp,
  input  logic       i_tx_done,
  output logic       o_trmt,
  output logic [7:0] o_tx_data,
  output logic       o_resp_sent
);

  logic       r_tx_busy;
  logic       r_buf_vld;
  logic [7:0] r_buf;
  logic       r_trmt;
  logic [7:0] r_tx_data;
  logic       r_resp_sent;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_busy   <= 1'b0;
      r_buf_vld   <= 1'b0;
      r_buf       <= 8'h00;
      r_trmt      <= 1'b0;
      r_tx_data   <= 8'h00;
      r_resp_sent <= 1'b0;
    end else begin
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
      if (!r_tx_busy) begin
        if (i_send_resp) begin
          r_trmt    <= 1'b1;
          r_tx_data <= i_resp;
          r_tx_busy <= 1'b1;
        end
      end else if (i_tx_done) begin
        r_resp_sent <= 1'b1;
        // A request arriving with tx_done is newer than anything buffered.
        if (i_send_resp) begin
          r_trmt    <= 1'b1;
          r_tx_data <= i_resp;
          r_buf_vld <= 1'b0;
        end else if (r_buf_vld) begin
          r_trmt    <= 1'b1;
          r_tx_data <= r_buf;
          r_buf_vld <= 1'b0;
        end else begin
          r_tx_busy <= 1'b0;
        end
      end else if (i_send_resp) begin
        r_buf     <= i_resp;
        r_buf_vld <= 1'b1;
      end
    end
  end

  assign o_trmt      = r_trmt;
  assign o_tx_data   = r_tx_data;
  assign o_resp_sent = r_resp_sent;

endmodule

// File: rtl/cmd_frame_assembler.sv
// Assembles 3-byte UART frames (cmd, data hi, data lo) into one command and
// drives responses back out. CMD_TIMEOUT_EN adds an inter-byte frame timeout.
// state | meaning
// IDLE  | waiting for cmd byte
// HIGH  | cmd captured, waiting for data[15:8]
// LOW   | data hi captured, waiting for data[7:0]
module cmd_frame_assembler #(
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input logic                  clk,
  input logic                  rst,
  cmd_frame_assembler_if.slave bus
);
  import quad_cmd_pkg::*;

  rx_state_e   r_state;
  logic [7:0]  r_shadow_cmd;
  logic [7:0]  r_shadow_hi;
  logic [7:0]  r_cmd;
  logic [15:0] r_data;
  logic        r_cmd_rdy;
  logic        r_clr_rx_rdy;
  logic        r_frm_err;
  logic        w_byte;
  logic        w_expire;

  // rx_rdy stays high until the UART sees our clear, so skip the cycle it echoes.
  assign w_byte = bus.rx_rdy & ~r_clr_rx_rdy;

`ifdef CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;

  assign w_expire = (r_state != IDLE) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES)) && !w_byte;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_byte || w_expire || (r_state == IDLE)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES == 0);
  assign w_expire    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shadow_cmd <= 8'h00;
      r_shadow_hi  <= 8'h00;
      r_cmd        <= 8'h00;
      r_data       <= 16'h0000;
      r_cmd_rdy    <= 1'b0;
      r_clr_rx_rdy <= 1'b0;
      r_frm_err    <= 1'b0;
    end else begin
      r_clr_rx_rdy <= w_byte;
      r_frm_err    <= 1'b0;
      if (bus.clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      if (w_byte) begin
        case (r_state)
          IDLE: begin
            r_shadow_cmd <= bus.rx_data;
            r_cmd_rdy    <= 1'b0;
            r_state      <= HIGH;
          end
          HIGH: begin
            r_shadow_hi <= bus.rx_data;
            r_state     <= LOW;
          end
          LOW: begin
            r_cmd     <= r_shadow_cmd;
            r_data    <= {r_shadow_hi, bus.rx_data};
            r_cmd_rdy <= 1'b1;
            r_state   <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_expire) begin
        r_state   <= IDLE;
        r_frm_err <= 1'b1;
      end
    end
  end

  assign bus.clr_rx_rdy = r_clr_rx_rdy;
  assign bus.cmd_rdy    = r_cmd_rdy;
  assign bus.cmd        = r_cmd;
  assign bus.data       = r_data;
  assign bus.frm_err    = r_frm_err;

  resp_tx_buffer u_resp_tx (
    .clk         (clk),
    .rst         (rst),
    .i_send_resp (bus.send_resp),
    .i_resp      (bus.resp),
    .i_tx_done   (bus.tx_done),
    .o_trmt      (bus.trmt),
    .o_tx_data   (bus.tx_data),
    .o_resp_sent (bus.resp_sent)
  );

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// Directed bench for cmd_frame_assembler: frame vector table plus TX/reset/timeout sequences.
module tb_cmd_frame_assembler;
  import quad_cmd_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  cmd_frame_assembler_if bus ();

  cmd_frame_assembler #(.TIMEOUT_CYCLES(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef CMD_TIMEOUT_EN
  localparam int LONG_GAP = 50;
`else
  localparam int LONG_GAP = 1000;
`endif

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int          gap;
    logic        coinc;
    logic [7:0]  e_cmd;
    logic [15:0] e_data;
  } vec_t;

  vec_t vt[4];
  int   n_vec = 0;
  int   n_err = 0;
  int   clr_cnt = 0;
  int   frm_cnt = 0;

  always @(negedge clk) begin
    if (bus.clr_rx_rdy) clr_cnt++;
    if (bus.frm_err) frm_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Holds rx_rdy one cycle past the clear pulse, as a UART reacting at the edge would.
  task automatic send_byte(input logic [7:0] b, input logic with_clr, output logic rdy);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_rdy = 1'b1; bus.rx_data = b; bus.clr_cmd_rdy = with_clr;
    do begin
      @(negedge clk); n++;
    end while (!bus.clr_rx_rdy && n < 20);
    bus.clr_cmd_rdy = 1'b0;
    rdy = bus.cmd_rdy;
    chk("clr_rx_rdy_seen", {31'b0, bus.clr_rx_rdy}, 32'd1);
    @(negedge clk);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic pulse_send(input logic [7:0] b);
    @(negedge clk); bus.send_resp = 1'b1; bus.resp = b;
    @(negedge clk); bus.send_resp = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); bus.tx_done = 1'b1;
    @(negedge clk); bus.tx_done = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  prev_cmd;
    logic [15:0] prev_data;
    logic        rdy;
    int          c0, f0, n;

    bus.rx_rdy = 0; bus.rx_data = 0; bus.clr_cmd_rdy = 0;
    bus.send_resp = 0; bus.resp = 0; bus.tx_done = 0;

    vt[0] = '{SET_THRST,  8'h06, 8'h66, LONG_GAP, 1'b0, SET_THRST,  16'h0666};
    vt[1] = '{SET_PITCH,  8'h12, 8'h34, 2,        1'b1, SET_PITCH,  16'h1234};
    vt[2] = '{MOTORS_OFF, 8'hFF, 8'h00, 0,        1'b0, MOTORS_OFF, 16'hFF00};
    vt[3] = '{SET_ROLL,   8'h00, 8'h10, 5,        1'b1, SET_ROLL,   16'h0010};

    repeat (3) @(negedge clk);
    chk("rst_cmd_rdy", {31'b0, bus.cmd_rdy}, 0);
    chk("rst_cmd_data", {8'b0, bus.cmd, bus.data}, 0);
    chk("rst_tx", {21'b0, bus.trmt, bus.tx_data, bus.resp_sent, bus.clr_rx_rdy, bus.frm_err}, 0);
    rst = 1'b0;

    prev_cmd = 8'h00; prev_data = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      c0 = clr_cnt;
      send_byte(vt[i].b0, 1'b0, rdy);
      repeat (vt[i].gap) @(negedge clk);
      chk("rdy_cleared_by_new_frame", {31'b0, bus.cmd_rdy}, 0);
      chk("cmd_held", {24'b0, bus.cmd}, {24'b0, prev_cmd});
      chk("data_held", {16'b0, bus.data}, {16'b0, prev_data});
      send_byte(vt[i].b1, 1'b0, rdy);
      repeat (vt[i].gap) @(negedge clk);
      send_byte(vt[i].b2, vt[i].coinc, rdy);
      chk("cmd_rdy_latency", {31'b0, rdy}, 1);
      chk("cmd_rdy_held", {31'b0, bus.cmd_rdy}, 1);
      chk("frame_cmd", {24'b0, bus.cmd}, {24'b0, vt[i].e_cmd});
      chk("frame_data", {16'b0, bus.data}, {16'b0, vt[i].e_data});
      chk("clr_rx_pulses", clr_cnt - c0, 3);
      prev_cmd = vt[i].e_cmd; prev_data = vt[i].e_data;
    end

    @(negedge clk); bus.clr_cmd_rdy = 1'b1;
    @(negedge clk); bus.clr_cmd_rdy = 1'b0;
    chk("clr_cmd_rdy", {31'b0, bus.cmd_rdy}, 0);
    chk("clr_keeps_cmd", {24'b0, bus.cmd}, {24'b0, SET_ROLL});
    chk("clr_keeps_data", {16'b0, bus.data}, 32'h0010);

    pulse_send(RESP_POS_ACK);
    chk("trmt_idle_send", {31'b0, bus.trmt}, 1);
    chk("tx_data_ack", {24'b0, bus.tx_data}, 32'hA5);
    @(negedge clk);
    chk("trmt_one_cycle", {31'b0, bus.trmt}, 0);
    pulse_send(8'h5A);
    chk("trmt_busy_buffered", {31'b0, bus.trmt}, 0);
    chk("tx_data_hold_busy", {24'b0, bus.tx_data}, 32'hA5);
    pulse_done();
    chk("trmt_from_buffer", {31'b0, bus.trmt}, 1);
    chk("tx_data_buffer", {24'b0, bus.tx_data}, 32'h5A);
    pulse_done();
    chk("resp_sent_empty", {31'b0, bus.resp_sent}, 1);
    chk("no_trmt_empty", {31'b0, bus.trmt}, 0);
    @(negedge clk);
    chk("resp_sent_one_cycle", {31'b0, bus.resp_sent}, 0);
    chk("tx_data_hold_idle", {24'b0, bus.tx_data}, 32'h5A);
    pulse_done();
    chk("tx_done_idle_ignored", {30'b0, bus.resp_sent, bus.trmt}, 0);

    pulse_send(8'h11);
    chk("trmt_11", {31'b0, bus.trmt}, 1);
    pulse_send(8'h22);
    pulse_send(8'h33);
    chk("trmt_overwrite_wait", {31'b0, bus.trmt}, 0);
    pulse_done();
    chk("trmt_last_wins", {31'b0, bus.trmt}, 1);
    chk("tx_data_last_wins", {24'b0, bus.tx_data}, 32'h33);
    pulse_done();
    chk("resp_sent_after_last", {31'b0, bus.resp_sent}, 1);

    f0 = frm_cnt;
    send_byte(SET_PITCH, 1'b0, rdy);
`ifdef CMD_TIMEOUT_EN
    n = 0;
    while (!bus.frm_err && n < 300) begin
      @(negedge clk); n++;
    end
    chk("frm_err_seen", {31'b0, bus.frm_err}, 1);
    chk("timeout_window", {31'b0, (n >= 95 && n <= 105)}, 1);
    @(negedge clk);
    chk("frm_err_one_cycle", {31'b0, bus.frm_err}, 0);
`else
    repeat (300) @(negedge clk);
    chk("no_frm_err", frm_cnt - f0, 0);
    send_byte(8'h00, 1'b0, rdy);
    send_byte(8'h10, 1'b0, rdy);
    chk("late_frame_cmd", {24'b0, bus.cmd}, {24'b0, SET_PITCH});
    chk("late_frame_data", {16'b0, bus.data}, 32'h0010);
`endif
    send_byte(SET_ROLL, 1'b0, rdy);
    send_byte(8'h00, 1'b0, rdy);
    send_byte(8'h10, 1'b0, rdy);
    chk("post_to_cmd", {24'b0, bus.cmd}, {24'b0, SET_ROLL});
    chk("post_to_data", {16'b0, bus.data}, 32'h0010);
    chk("post_to_rdy", {31'b0, bus.cmd_rdy}, 1);

    pulse_send(8'h44);
    pulse_send(8'h55);
    send_byte(SET_YAW, 1'b0, rdy);
    send_byte(EMER_LAND, 1'b0, rdy);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_cmd", {8'b0, bus.cmd, bus.data}, 0);
    chk("midrst_out", {20'b0, bus.cmd_rdy, bus.trmt, bus.tx_data, bus.resp_sent, bus.frm_err}, 0);
    @(negedge clk); rst = 1'b0;
    pulse_done();
    chk("midrst_buffer_lost", {30'b0, bus.trmt, bus.resp_sent}, 0);
    send_byte(MOTORS_OFF, 1'b0, rdy);
    send_byte(8'h00, 1'b0, rdy);
    send_byte(8'h00, 1'b0, rdy);
    chk("after_rst_cmd", {24'b0, bus.cmd}, {24'b0, MOTORS_OFF});
    chk("after_rst_data", {16'b0, bus.data}, 0);
    chk("after_rst_rdy", {31'b0, bus.cmd_rdy}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_frame_assembler.md
Name: cmd_frame_assembler

Overview:
- Sits between the quadcopter's UART transceiver and the command-config block.
- Assembles the host's 3-byte frames into one command: cmd byte, then data[15:8], then data[7:0].
- Presents the result with a ready flag.
- Transmits one-byte responses (e.g. positive ack 8'hA5) back through the UART transmitter, with a 1-deep holding buffer.

Parameters:
- TIMEOUT_CYCLES, 500000, max clk cycles between bytes of one frame before the partial frame is discarded (10 ms at 50 MHz). Used only with CMD_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx_rdy  input  1  UART receiver has a byte (level, held until cleared)
- rx_data  input  8  received byte, valid while rx_rdy=1
- clr_rx_rdy  output  1  one-cycle pulse acknowledging rx_data
- cmd_rdy  output  1  assembled frame available
- cmd  output  8  command byte of last complete frame
- data  output  16  data word of last complete frame
- clr_cmd_rdy  input  1  consumer acknowledges frame
- send_resp  input  1  one-cycle request to transmit resp
- resp  input  8  response byte, sampled when send_resp=1
- resp_sent  output  1  one-cycle pulse when the UART reports the response byte done
- trmt  output  1  one-cycle pulse starting UART transmission
- tx_data  output  8  byte presented to the UART transmitter
- tx_done  input  1  UART transmitter finished a byte (one-cycle pulse)
- frm_err  output  1  one-cycle pulse when a partial frame is dropped

Behaviour:
- Reset: all outputs 0, FSM=IDLE, shadow registers 0, tx_busy=0, buffer empty.
- RX FSM states: IDLE, HIGH, LOW. In every state, rx_rdy=1 produces clr_rx_rdy on the same cycle, registered so the pulse appears the cycle after rx_rdy is sampled. Only one byte is consumed per rx_rdy assertion.
- IDLE on byte: shadow_cmd<=rx_data; cmd_rdy<=0 (a new frame invalidates the old one); go to HIGH.
- HIGH on byte: shadow_hi<=rx_data; go to LOW.
- LOW on byte: cmd<=shadow_cmd; data<={shadow_hi,rx_data}; cmd_rdy<=1 on the next edge; go to IDLE.
- Latency: cmd_rdy rises 1 cycle after the third byte is sampled.
- cmd/data outputs change only on frame completion, so they are stable while cmd_rdy=1.
- cmd_rdy clears on clr_cmd_rdy=1 or on the first byte of the next frame.
- If completion and clr_cmd_rdy coincide, set wins.
- TX path: tx_busy is set by trmt and cleared by tx_done.
  - send_resp while !tx_busy and buffer empty: trmt=1 on the next cycle, tx_data=resp.
  - send_resp while tx_busy: resp goes into the 1-deep buffer. When tx_done arrives, trmt fires the following cycle with the buffered byte.
  - send_resp with the buffer full: the newest byte overwrites the buffer (last response wins).
  - tx_done with nothing buffered: resp_sent pulses the same cycle as tx_done (registered, +1 cycle).
- tx_data holds the last transmitted byte between transmissions.
- Reset mid-frame or mid-transmit: immediate return to the reset state. The partial frame and buffered byte are lost; no frm_err.
- tx_done while !tx_busy: ignored.

Optional Feature:
- Macro CMD_TIMEOUT_EN.
- Defined: an inter-byte counter (width $clog2(TIMEOUT_CYCLES+1)) clears on every consumed byte and increments in HIGH/LOW. On reaching TIMEOUT_CYCLES the FSM returns to IDLE, shadows are kept but ignored, and frm_err pulses one cycle. If a byte arrives on the same cycle as expiry, the byte wins and no timeout occurs.
- Undefined: no counter; FSM waits indefinitely; frm_err tied 0.

Decomposition:
- Package quad_cmd_pkg: enum for rx states IDLE/HIGH/LOW; localparams for command codes SET_PITCH 8'h02 through MOTORS_OFF 8'h08; RESP_POS_ACK 8'hA5.
- One sub-module, resp_tx_buffer: owns tx_busy, 1-deep buffer, trmt/tx_data/resp_sent.
- The FSM and timeout stay in the top module.

Test Plan:
- Bytes 8'h05, 8'h06, 8'h66 with 1000-cycle gaps -> cmd_rdy=1 one cycle after third byte; cmd=8'h05, data=16'h0666; three clr_rx_rdy pulses.
- cmd_rdy high, then clr_cmd_rdy pulse -> cmd_rdy=0 next cycle, cmd/data unchanged.
- Third byte completion coincident with clr_cmd_rdy -> cmd_rdy=1.
- send_resp with 8'hA5 while idle -> trmt next cycle, tx_data=8'hA5. Second send_resp 8'h5A during busy -> after tx_done, trmt fires with 8'h5A.
- With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 8'h02, wait 100 cycles -> frm_err pulse, FSM IDLE. Then 8'h03, 8'h00, 8'h10 -> cmd=8'h03, data=16'h0010.
- Assert rst after second byte, release, send full frame 8'h08, 8'h00, 8'h00 -> cmd=8'h08, data=0, cmd_rdy=1.
